// File: rtl/ps2_kbd_decoder_pkg.sv
// Shared types and constants for the PS/2 keyboard decoder.
// Receiver states, prefix bytes and the suppressed-code list.
package ps2_pkg;

    typedef enum logic [2:0] {
        RESYNC,
        IDLE,
        DATA,
        PARITY,
        STOP
    } rx_state_e;

    localparam logic [7:0] PS2_PFX_EXT   = 8'hE0;
    localparam logic [7:0] PS2_PFX_REL   = 8'hF0;
    localparam logic [7:0] PS2_PFX_PAUSE = 8'hE1;

    localparam int PS2_N_SUPP = 6;
    localparam logic [PS2_N_SUPP-1:0][7:0] PS2_SUPP = {
        8'hAA, 8'hFA, 8'hEE, 8'hFE, 8'h00, 8'hFF
    };

    function automatic logic is_suppressed(input logic [7:0] b);
        logic hit;
        hit = 1'b0;
        for (int i = 0; i < PS2_N_SUPP; i++) begin
            if (PS2_SUPP[i] == b) hit = 1'b1;
        end
        return hit;
    endfunction

endpackage

// File: rtl/ps2_kbd_decoder_if.sv
// PS/2 line pair plus decoded byte/key event bundle.
// master = I/O block side, slave = decoder side.
interface ps2_kbd_if;
    import ps2_pkg::*;

    logic       ps2_clk;
    logic       ps2_data;
    logic       byte_valid;
    logic [7:0] byte_data;
    logic       key_strobe;
    logic [7:0] key_code;
    logic       key_extended;
    logic       key_pressed;
    logic       frame_err;

    modport master (
        output ps2_clk, ps2_data,
        input  byte_valid, byte_data, key_strobe,
        input  key_code, key_extended, key_pressed, frame_err
    );

    modport slave (
        input  ps2_clk, ps2_data,
        output byte_valid, byte_data, key_strobe,
        output key_code, key_extended, key_pressed, frame_err
    );

endinterface

// File: rtl/ps2_kbd_decoder_frame_rx.sv
// PS/2 frame receiver: synchronisers, falling-edge detect,
// 11-bit frame FSM with odd-parity check and a watchdog.
module ps2_frame_rx
    import ps2_pkg::*;
#(
    parameter int TIMEOUT_BITS = 12
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic       i_ps2_clk,
    input  logic       i_ps2_data,
    output logic       o_byte_valid,
    output logic [7:0] o_byte_data,
    output logic       o_frame_err
);

    localparam logic [TIMEOUT_BITS-1:0] W_MAX = '1;

    logic [1:0]              r_clk_sync;
    logic [1:0]              r_dat_sync;
    logic                    r_sclk_prev;
    rx_state_e               r_state;
    logic [7:0]              r_shift;
    logic [2:0]              r_bit_cnt;
    logic                    r_par;
    logic                    r_par_ok;
    logic [TIMEOUT_BITS-1:0] r_wd;
    logic                    r_byte_valid;
    logic [7:0]              r_byte_data;
    logic                    r_frame_err;

    logic                    w_sclk;
    logic                    w_sdat;
    logic                    w_fe;
    rx_state_e               w_state_nxt;
    logic [7:0]              w_shift_nxt;
    logic [2:0]              w_cnt_nxt;
    logic                    w_par_nxt;
    logic                    w_pok_nxt;
    logic [TIMEOUT_BITS-1:0] w_wd_nxt;
    logic                    w_wd_hit;
    logic                    w_good;
    logic                    w_err;

    assign w_sclk = r_clk_sync[1];
    assign w_sdat = r_dat_sync[1];
    assign w_fe   = r_sclk_prev & ~w_sclk;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_clk_sync  <= 2'b11;
            r_dat_sync  <= 2'b11;
            r_sclk_prev <= 1'b1;
        end else begin
            r_clk_sync  <= {r_clk_sync[0], i_ps2_clk};
            r_dat_sync  <= {r_dat_sync[0], i_ps2_data};
            r_sclk_prev <= w_sclk;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_shift_nxt = r_shift;
        w_cnt_nxt   = r_bit_cnt;
        w_par_nxt   = r_par;
        w_pok_nxt   = r_par_ok;
        w_wd_nxt    = r_wd + TIMEOUT_BITS'(1);
        w_wd_hit    = (w_wd_nxt == W_MAX);
        w_good      = 1'b0;
        w_err       = 1'b0;
        unique case (r_state)
            RESYNC: begin
                if (!w_sclk) begin
                    w_wd_nxt = '0;
                end else if (w_wd_hit) begin
                    w_wd_nxt    = '0;
                    w_state_nxt = IDLE;
                end
            end
            IDLE: begin
                w_wd_nxt = '0;
                if (w_fe && !w_sdat) begin
                    w_shift_nxt = '0;
                    w_cnt_nxt   = '0;
                    w_par_nxt   = 1'b1;
                    w_state_nxt = DATA;
                end
            end
            DATA: begin
                if (w_fe) begin
                    w_shift_nxt = {w_sdat, r_shift[7:1]};
                    w_par_nxt   = r_par ^ w_sdat;
                    w_cnt_nxt   = r_bit_cnt + 3'd1;
                    if (r_bit_cnt == 3'd7) w_state_nxt = PARITY;
                end
            end
            PARITY: begin
                if (w_fe) begin
                    w_pok_nxt   = (w_sdat == r_par);
                    w_state_nxt = STOP;
                end
            end
            STOP: begin
                if (w_fe) begin
                    w_good      = w_sdat & r_par_ok;
                    w_err       = ~(w_sdat & r_par_ok);
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = RESYNC;
        endcase
        // An edge always beats the watchdog in the same cycle.
        if (r_state inside {DATA, PARITY, STOP}) begin
            if (w_fe) begin
                w_wd_nxt = '0;
            end else if (w_wd_hit) begin
                w_wd_nxt    = '0;
                w_err       = 1'b1;
                w_state_nxt = IDLE;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state      <= RESYNC;
            r_shift      <= '0;
            r_bit_cnt    <= '0;
            r_par        <= 1'b0;
            r_par_ok     <= 1'b0;
            r_wd         <= '0;
            r_byte_valid <= 1'b0;
            r_byte_data  <= '0;
            r_frame_err  <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_shift      <= w_shift_nxt;
            r_bit_cnt    <= w_cnt_nxt;
            r_par        <= w_par_nxt;
            r_par_ok     <= w_pok_nxt;
            r_wd         <= w_wd_nxt;
            r_byte_valid <= w_good;
            r_frame_err  <= w_err;
            if (w_good) r_byte_data <= r_shift;
        end
    end

    assign o_byte_valid = r_byte_valid;
    assign o_byte_data  = r_byte_data;
    assign o_frame_err  = r_frame_err;

endmodule

// File: rtl/ps2_kbd_decoder.sv
// PS/2 keyboard decoder top: frame receiver plus E0/F0 prefix
// folding into single make/break key events.
module ps2_kbd_decoder
    import ps2_pkg::*;
#(
    parameter int TIMEOUT_BITS = 12
) (
    input  logic     i_clk_sys,
    input  logic     i_reset,
    ps2_kbd_if.slave io_kbd
);

    logic       w_byte_valid;
    logic [7:0] w_byte_data;
    logic       w_frame_err;
    logic       w_ext_nxt;
    logic       w_rel_nxt;
    logic       w_emit;

    logic       r_ext;
    logic       r_rel;
    logic       r_strobe;
    logic [7:0] r_code;
    logic       r_kext;
    logic       r_kpr;

    ps2_frame_rx #(
        .TIMEOUT_BITS (TIMEOUT_BITS)
    ) u_rx (
        .i_clk        (i_clk_sys),
        .i_reset      (i_reset),
        .i_ps2_clk    (io_kbd.ps2_clk),
        .i_ps2_data   (io_kbd.ps2_data),
        .o_byte_valid (w_byte_valid),
        .o_byte_data  (w_byte_data),
        .o_frame_err  (w_frame_err)
    );

    always_comb begin
        w_ext_nxt = r_ext;
        w_rel_nxt = r_rel;
        w_emit    = 1'b0;
        if (w_frame_err) begin
            w_ext_nxt = 1'b0;
            w_rel_nxt = 1'b0;
        end else if (w_byte_valid) begin
            unique case (1'b1)
                (w_byte_data == PS2_PFX_EXT):   w_ext_nxt = 1'b1;
                (w_byte_data == PS2_PFX_REL):   w_rel_nxt = 1'b1;
                (w_byte_data == PS2_PFX_PAUSE): ;
                is_suppressed(w_byte_data): begin
                    w_ext_nxt = 1'b0;
                    w_rel_nxt = 1'b0;
                end
                default: begin
                    w_emit    = 1'b1;
                    w_ext_nxt = 1'b0;
                    w_rel_nxt = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge i_clk_sys) begin
        if (i_reset) begin
            r_ext    <= 1'b0;
            r_rel    <= 1'b0;
            r_strobe <= 1'b0;
            r_code   <= '0;
            r_kext   <= 1'b0;
            r_kpr    <= 1'b0;
        end else begin
            r_ext    <= w_ext_nxt;
            r_rel    <= w_rel_nxt;
            r_strobe <= w_emit;
            if (w_emit) begin
                r_code <= w_byte_data;
                r_kext <= r_ext;
                r_kpr  <= ~r_rel;
            end
        end
    end

    assign io_kbd.byte_valid   = w_byte_valid;
    assign io_kbd.byte_data    = w_byte_data;
    assign io_kbd.frame_err    = w_frame_err;
    assign io_kbd.key_strobe   = r_strobe;
    assign io_kbd.key_code     = r_code;
    assign io_kbd.key_extended = r_kext;
    assign io_kbd.key_pressed  = r_kpr;

endmodule

// File: tb/tb_ps2_kbd_decoder.sv
// Directed bench for ps2_kbd_decoder: frames, prefixes,
// parity error, watchdog timeout and mid-frame reset.
module tb_ps2_kbd_decoder;
    import ps2_pkg::*;

    localparam int HALF = 8;

    logic clk;
    logic reset;
    int   cyc;
    int   total;
    int   bad;

    int   n_bv, n_ks, n_fe;
    int   bv_cyc, ks_cyc, fe_cyc;
    int   last_bd;
    int   fall_cyc;
    int   s_bv, s_ks, s_fe;

    ps2_kbd_if kbd ();

    ps2_kbd_decoder #(
        .TIMEOUT_BITS (12)
    ) dut (
        .i_clk_sys (clk),
        .i_reset   (reset),
        .io_kbd    (kbd.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (!reset) begin
            if (kbd.byte_valid) begin
                n_bv    = n_bv + 1;
                bv_cyc  = cyc;
                last_bd = int'(kbd.byte_data);
            end
            if (kbd.key_strobe) begin
                n_ks   = n_ks + 1;
                ks_cyc = cyc;
            end
            if (kbd.frame_err) begin
                n_fe   = n_fe + 1;
                fe_cyc = cyc;
            end
        end
    end

    task automatic chk(input string tag, input int obs,
                       input int exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h",
                   tag, obs, exp);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic b);
        @(posedge clk);
        #1 kbd.ps2_data = b;
        wait_cyc(HALF);
        kbd.ps2_clk = 1'b0;
        fall_cyc    = cyc;
        wait_cyc(HALF);
        kbd.ps2_clk = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] b,
                              input logic flip_par);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(b[i]);
        send_bit((~^b) ^ flip_par);
        send_bit(1'b1);
        wait_cyc(20);
    endtask

    task automatic snap();
        s_bv = n_bv;
        s_ks = n_ks;
        s_fe = n_fe;
    endtask

    task automatic chk_key(input string tag, input int code,
                           input int ext, input int pr);
        chk({tag, "_ks"},   n_ks - s_ks, 1);
        chk({tag, "_code"}, int'(kbd.key_code), code);
        chk({tag, "_ext"},  int'(kbd.key_extended), ext);
        chk({tag, "_pr"},   int'(kbd.key_pressed), pr);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_bv"},  int'(kbd.byte_valid), 0);
        chk({tag, "_bd"},  int'(kbd.byte_data), 0);
        chk({tag, "_ks"},  int'(kbd.key_strobe), 0);
        chk({tag, "_kc"},  int'(kbd.key_code), 0);
        chk({tag, "_ke"},  int'(kbd.key_extended), 0);
        chk({tag, "_kp"},  int'(kbd.key_pressed), 0);
        chk({tag, "_fe"},  int'(kbd.frame_err), 0);
    endtask

    initial begin
        logic [7:0] pb;
        cyc = 0; total = 0; bad = 0;
        n_bv = 0; n_ks = 0; n_fe = 0;
        bv_cyc = 0; ks_cyc = 0; fe_cyc = 0;
        last_bd = 0; fall_cyc = 0;
        kbd.ps2_clk  = 1'b1;
        kbd.ps2_data = 1'b1;
        reset = 1'b1;
        wait_cyc(4);
        chk_zero("rst");
        reset = 1'b0;
        wait_cyc(4200);

        // 1: plain make 0x1C, latency check
        snap();
        send_frame(8'h1C, 1'b0);
        chk("t1_bv", n_bv - s_bv, 1);
        chk("t1_bd", last_bd, 'h1C);
        chk("t1_bv_lat", bv_cyc - fall_cyc, 3);
        chk("t1_ks_lat", ks_cyc - fall_cyc, 4);
        chk_key("t1", 'h1C, 0, 1);

        // 2: break F0 1C
        snap();
        send_frame(8'hF0, 1'b0);
        chk("t2_f0_ks", n_ks - s_ks, 0);
        chk("t2_f0_bv", n_bv - s_bv, 1);
        send_frame(8'h1C, 1'b0);
        chk_key("t2", 'h1C, 0, 0);

        // 3: extended break E0 F0 75, then bare 75
        snap();
        send_frame(8'hE0, 1'b0);
        send_frame(8'hF0, 1'b0);
        send_frame(8'h75, 1'b0);
        chk_key("t3a", 'h75, 1, 0);
        snap();
        send_frame(8'h75, 1'b0);
        chk_key("t3b", 'h75, 0, 1);

        // repeated E0 is idempotent
        snap();
        send_frame(8'hE0, 1'b0);
        send_frame(8'hE0, 1'b0);
        send_frame(8'h6B, 1'b0);
        chk_key("e0e0", 'h6B, 1, 1);

        // E1 keeps the pending break flag
        snap();
        send_frame(8'hF0, 1'b0);
        send_frame(8'hE1, 1'b0);
        send_frame(8'h14, 1'b0);
        chk_key("e1", 'h14, 0, 0);

        // FA is suppressed and clears the pending E0
        snap();
        send_frame(8'hE0, 1'b0);
        send_frame(8'hFA, 1'b0);
        chk("fa_ks", n_ks - s_ks, 0);
        snap();
        send_frame(8'h1C, 1'b0);
        chk_key("fa", 'h1C, 0, 1);

        // 4: parity error
        snap();
        send_frame(8'h1C, 1'b1);
        chk("t4_fe", n_fe - s_fe, 1);
        chk("t4_bv", n_bv - s_bv, 0);
        chk("t4_ks", n_ks - s_ks, 0);
        snap();
        send_frame(8'h1C, 1'b0);
        chk_key("t4b", 'h1C, 0, 1);

        // 5: truncated frame after E0, watchdog timeout
        send_frame(8'hE0, 1'b0);
        snap();
        pb = 8'h29;
        send_bit(1'b0);
        for (int i = 0; i < 5; i++) send_bit(pb[i]);
        wait_cyc(4200);
        chk("t5_fe", n_fe - s_fe, 1);
        chk("t5_fe_lat", fe_cyc - fall_cyc, 4098);
        chk("t5_bv", n_bv - s_bv, 0);
        snap();
        send_frame(8'h29, 1'b0);
        chk_key("t5b", 'h29, 0, 1);

        // 6: reset after the 4th data bit
        snap();
        pb = 8'h5A;
        send_bit(1'b0);
        for (int i = 0; i < 4; i++) send_bit(pb[i]);
        @(posedge clk);
        #1 reset = 1'b1;
        wait_cyc(3);
        chk_zero("t6_rst");
        reset = 1'b0;
        for (int i = 4; i < 8; i++) send_bit(pb[i]);
        send_bit(~^pb);
        send_bit(1'b1);
        wait_cyc(20);
        chk("t6_bv", n_bv - s_bv, 0);
        chk("t6_fe", n_fe - s_fe, 0);
        chk("t6_ks", n_ks - s_ks, 0);
        wait_cyc(4200);
        snap();
        send_frame(8'hAA, 1'b0);
        chk("t6_aa_bv", n_bv - s_bv, 1);
        chk("t6_aa_bd", last_bd, 'hAA);
        chk("t6_aa_ks", n_ks - s_ks, 0);
        chk("t6_aa_fe", n_fe - s_fe, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
